// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Y86-64 fetch stage together with the F (predicted PC) and D (fetch/decode)
// pipeline registers. Selects the fetch PC, splits the instruction bytes,
// predicts the next PC, computes the fetch status and registers the result
// into D under the hazard controller's stall/bubble controls.
//
// Optional feature macro: FETCH_PERF_CNT_EN
//   When defined, adds perf_fetch_o / perf_stall_o 32-bit event counters.
//
// Ports:
//   clk_i, rst_n_i                 clock (rising edge), async active-low reset
//   F_stall_i                      hold F register
//   D_stall_i, D_bubble_i          hold / bubble the D register (stall wins)
//   M_icode_i, M_Cnd_i, M_valA_i   mispredicted-jump redirect from M
//   W_icode_i, W_valM_i            ret redirect from W
//   imem_addr_o, imem_data_i       fetch address and ten combinational bytes
//   F_predPC_o                     F register contents
//   D_stat_o .. D_valP_o           D register contents
//   perf_fetch_o, perf_stall_o     (FETCH_PERF_CNT_EN only) event counters
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int unsigned IMEM_BYTES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        F_stall_i,
  input  logic        D_stall_i,
  input  logic        D_bubble_i,
  input  logic [3:0]  M_icode_i,
  input  logic        M_Cnd_i,
  input  logic [63:0] M_valA_i,
  input  logic [3:0]  W_icode_i,
  input  logic [63:0] W_valM_i,
  output logic [63:0] imem_addr_o,
  input  logic [79:0] imem_data_i,
  output logic [63:0] F_predPC_o,
  output logic [2:0]  D_stat_o,
  output logic [3:0]  D_icode_o,
  output logic [3:0]  D_ifun_o,
  output logic [3:0]  D_rA_o,
  output logic [3:0]  D_rB_o,
  output logic [63:0] D_valC_o,
  output logic [63:0] D_valP_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_o,
  output logic [31:0] perf_stall_o
`endif
);

  // Instruction codes
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] RNONE   = 4'hF;

  // Status codes
  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  // Highest legal fetch address: all ten bytes must lie inside the memory.
  localparam logic [63:0] IMEM_LIMIT = 64'(IMEM_BYTES) - 64'd10;

  function automatic logic need_regids_f(input logic [3:0] icode);
    case (icode)
      IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ, IOPQ, IPUSHQ, IPOPQ: need_regids_f = 1'b1;
      default:                                                need_regids_f = 1'b0;
    endcase
  endfunction

  function automatic logic need_valc_f(input logic [3:0] icode);
    case (icode)
      IIRMOVQ, IRMMOVQ, IMRMOVQ, IJXX, ICALL: need_valc_f = 1'b1;
      default:                                need_valc_f = 1'b0;
    endcase
  endfunction

  function automatic logic instr_valid_f(input logic [3:0] icode);
    instr_valid_f = (icode <= IPOPQ);
  endfunction

  logic [63:0] r_predpc;
  logic [2:0]  r_d_stat;
  logic [3:0]  r_d_icode;
  logic [3:0]  r_d_ifun;
  logic [3:0]  r_d_ra;
  logic [3:0]  r_d_rb;
  logic [63:0] r_d_valc;
  logic [63:0] r_d_valp;

  logic [63:0] w_f_pc;
  logic        w_imem_error;
  logic [3:0]  w_icode;
  logic [3:0]  w_ifun;
  logic        w_need_regids;
  logic        w_need_valc;
  logic [3:0]  w_ra;
  logic [3:0]  w_rb;
  logic [63:0] w_valc;
  logic [63:0] w_valp;
  logic [63:0] w_predpc;
  logic [2:0]  w_stat;

  // Fetch PC selection: a mispredicted jump in M outranks a ret in W.
  always_comb begin
    w_f_pc = r_predpc;
    if (M_icode_i == IJXX && !M_Cnd_i) begin
      w_f_pc = M_valA_i;
    end else if (W_icode_i == IRET) begin
      w_f_pc = W_valM_i;
    end else begin
      w_f_pc = r_predpc;
    end
  end

  assign imem_addr_o  = w_f_pc;
  assign w_imem_error = (w_f_pc > IMEM_LIMIT);

  // Instruction split, field extraction, next-PC prediction and status.
  always_comb begin
    w_icode = imem_data_i[7:4];
    w_ifun  = imem_data_i[3:0];
    if (w_imem_error) begin
      w_icode = INOP;
      w_ifun  = 4'h0;
    end else begin
      w_icode = imem_data_i[7:4];
      w_ifun  = imem_data_i[3:0];
    end

    w_need_regids = need_regids_f(w_icode);
    w_need_valc   = need_valc_f(w_icode);

    w_ra = RNONE;
    w_rb = RNONE;
    if (w_need_regids) begin
      w_ra = imem_data_i[15:12];
      w_rb = imem_data_i[11:8];
    end else begin
      w_ra = RNONE;
      w_rb = RNONE;
    end

    // Constant word follows the register byte when one is present.
    w_valc = 64'd0;
    if (!w_need_valc) begin
      w_valc = 64'd0;
    end else if (w_need_regids) begin
      w_valc = imem_data_i[79:16];
    end else begin
      w_valc = imem_data_i[71:8];
    end

    w_valp = w_f_pc + 64'd1
           + (w_need_regids ? 64'd1 : 64'd0)
           + (w_need_valc   ? 64'd8 : 64'd0);

    // Jumps and calls are always predicted taken.
    w_predpc = w_valp;
    if (w_icode == IJXX || w_icode == ICALL) begin
      w_predpc = w_valc;
    end else begin
      w_predpc = w_valp;
    end

    w_stat = SAOK;
    if (w_imem_error) begin
      w_stat = SADR;
    end else if (!instr_valid_f(w_icode)) begin
      w_stat = SINS;
    end else if (w_icode == IHALT) begin
      w_stat = SHLT;
    end else begin
      w_stat = SAOK;
    end
  end

  // F register: predicted PC, held while F is stalled.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_predpc <= RESET_PC;
    end else if (!F_stall_i) begin
      r_predpc <= w_predpc;
    end else begin
      r_predpc <= r_predpc;
    end
  end

  // D register: stall holds, bubble loads a nop, otherwise capture fetch.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_d_stat  <= SAOK;
      r_d_icode <= INOP;
      r_d_ifun  <= 4'h0;
      r_d_ra    <= RNONE;
      r_d_rb    <= RNONE;
      r_d_valc  <= 64'd0;
      r_d_valp  <= 64'd0;
    end else if (D_stall_i) begin
      r_d_stat  <= r_d_stat;
      r_d_icode <= r_d_icode;
      r_d_ifun  <= r_d_ifun;
      r_d_ra    <= r_d_ra;
      r_d_rb    <= r_d_rb;
      r_d_valc  <= r_d_valc;
      r_d_valp  <= r_d_valp;
    end else if (D_bubble_i) begin
      r_d_stat  <= SAOK;
      r_d_icode <= INOP;
      r_d_ifun  <= 4'h0;
      r_d_ra    <= RNONE;
      r_d_rb    <= RNONE;
      r_d_valc  <= 64'd0;
      r_d_valp  <= 64'd0;
    end else begin
      r_d_stat  <= w_stat;
      r_d_icode <= w_icode;
      r_d_ifun  <= w_ifun;
      r_d_ra    <= w_ra;
      r_d_rb    <= w_rb;
      r_d_valc  <= w_valc;
      r_d_valp  <= w_valp;
    end
  end

  assign F_predPC_o = r_predpc;
  assign D_stat_o   = r_d_stat;
  assign D_icode_o  = r_d_icode;
  assign D_ifun_o   = r_d_ifun;
  assign D_rA_o     = r_d_ra;
  assign D_rB_o     = r_d_rb;
  assign D_valC_o   = r_d_valc;
  assign D_valP_o   = r_d_valp;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_stall;
  logic        w_d_load;

  assign w_d_load = !D_stall_i && !D_bubble_i;

  // Event counters: fetches captured into D and stalled D cycles (wrapping).
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_perf_fetch <= 32'd0;
      r_perf_stall <= 32'd0;
    end else begin
      r_perf_fetch <= w_d_load  ? (r_perf_fetch + 32'd1) : r_perf_fetch;
      r_perf_stall <= D_stall_i ? (r_perf_stall + 32'd1) : r_perf_stall;
    end
  end

  assign perf_fetch_o = r_perf_fetch;
  assign perf_stall_o = r_perf_stall;
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Fetch stage of the five-stage Y86-64 pipeline, together with the F (predicted-PC) and D (fetch/decode) pipeline registers. It selects the fetch PC, decodes instruction bytes from instruction memory into icode/ifun/rA/rB/valC/valP, predicts the next PC and computes fetch status. It registers the results into the D stage under the F_stall_o/D_stall_o/D_bubble_o controls produced by the pipeline hazard controller. It directly feeds the decode stage.

## Interface
Parameters:
- RESET_PC, 64'h0, value loaded into F_predPC on reset.
- IMEM_BYTES, 1024, instruction memory size in bytes; bounds the legal fetch address.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_n_i  input  1  reset, asynchronous, active-low.
- F_stall_i  input  1  hold F register.
- D_stall_i  input  1  hold D register.
- D_bubble_i  input  1  load bubble into D register.
- M_icode_i  input  4  memory-stage icode.
- M_Cnd_i  input  1  memory-stage branch condition.
- M_valA_i  input  64  fall-through PC of the jump in M.
- W_icode_i  input  4  write-back icode.
- W_valM_i  input  64  return address popped by ret.
- imem_addr_o  output  64  fetch address (f_pc).
- imem_data_i  input  80  ten bytes starting at imem_addr_o, combinational; byte k at [8k+7:8k].
- F_predPC_o  output  64  F register contents.
- D_stat_o  output  3  D status.
- D_icode_o  output  4  D icode.
- D_ifun_o  output  4  D ifun.
- D_rA_o  output  4  D rA.
- D_rB_o  output  4  D rB.
- D_valC_o  output  64  D constant word.
- D_valP_o  output  64  D incremented PC.

## Operation
- f_pc selection, in priority order: M_icode_i==IJXX && !M_Cnd_i gives M_valA_i; else W_icode_i==IRET gives W_valM_i; else F_predPC.
- imem_error = (f_pc > IMEM_BYTES-10), unsigned 64-bit compare.
- Instruction split: icode=byte0[7:4], ifun=byte0[3:0]. On imem_error, force icode=INOP and ifun=0.
- instr_valid: icode in IHALT..IPOPQ (0x0–0xB).
- need_regids: IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ, IOPQ, IPUSHQ, IPOPQ.
- need_valC: IIRMOVQ, IRMMOVQ, IMRMOVQ, IJXX, ICALL.
- rA/rB: byte1[7:4]/byte1[3:0] if need_regids, else RNONE (4'hF).
- valC: little-endian bytes 1..8 if !need_regids, else bytes 2..9. Zero when !need_valC.
- valP = f_pc + 1 + need_regids + 8·need_valC, modulo 2^64.
- f_predPC: valC for IJXX or ICALL (always-taken prediction), else valP.
- f_stat, in priority order: imem_error gives SADR; !instr_valid gives SINS; icode==IHALT gives SHLT; else SAOK.
- F register on clk edge: if !F_stall_i, F_predPC <= f_predPC; else hold.
- D register on clk edge, in priority order: D_stall_i holds; else D_bubble_i loads the bubble (stat SAOK, icode INOP, ifun 0, rA/rB 4'hF, valC 0, valP 0); else loads the f_* values. If D_stall_i and D_bubble_i are both asserted, stall wins.

## Timing
- Reset (rst_n_i low, asynchronous): F_predPC=RESET_PC; D outputs take the bubble values (D_stat_o=SAOK, D_icode_o=INOP, D_ifun_o=0, D_rA_o=D_rB_o=4'hF, D_valC_o=0, D_valP_o=0).
- Reset release: the first fetch is at RESET_PC in the first cycle after deassertion. Reset asserted mid-operation discards all in-flight state immediately.
- imem_addr_o is combinational from F_predPC, M_* and W_* inputs in the same cycle.
- D outputs appear one cycle after fetch (latency 1).
- Redirects take effect the same cycle they appear: a mispredict in M or a ret in W changes imem_addr_o that cycle, with no extra bubble.
- Mispredict and ret in the same cycle: the mispredict wins.
- F_stall_i holds F_predPC even while a redirect is present; the redirect stays visible on imem_addr_o.

## Configuration
- FETCH_PERF_CNT_EN defined: adds output ports perf_fetch_o (32-bit) and perf_stall_o (32-bit), both reset to 0.
  - perf_fetch_o increments on each edge where D loads f_* values.
  - perf_stall_o increments on each edge with D_stall_i high.
  - Both counters wrap modulo 2^32.
- FETCH_PERF_CNT_EN undefined: these ports and counters are absent. Behaviour is otherwise identical.

## Test plan
- Reset with RESET_PC=0 -> F_predPC_o=0, D_icode_o=1, D_stat_o=SAOK, D_rA_o=F; on release imem_addr_o=0.
- imem bytes 30 F2 0A 00 00 00 00 00 00 00 at 0 -> next edge D_icode_o=3, D_rB_o=2, D_valC_o=0xA, D_valP_o=10, F_predPC_o=10.
- jmp at 0x20 to 0x100 -> F_predPC_o=0x100, D_valP_o=0x29. Later M_icode_i=7, M_Cnd_i=0, M_valA_i=0x29 -> imem_addr_o=0x29 in the same cycle.
- F_stall_i=D_stall_i=1 for 2 cycles -> F_predPC_o and all D outputs unchanged. Then D_bubble_i=1 -> D_icode_o=INOP, D_valP_o=0.
- byte0=0xC0 -> D_stat_o=SINS. F_predPC at IMEM_BYTES-9 -> D_stat_o=SADR, D_icode_o=INOP.
- W_icode_i=9, W_valM_i=0x40 -> imem_addr_o=0x40. Adding a simultaneous M mispredict with M_valA_i=0x50 -> imem_addr_o=0x50.
